// File: rtl/sram_word_ctrl.sv
// Word-access controller for one asynchronous 32-bit SRAM: turns a held core request into a timed
// read or write cycle with every SRAM pin driven from a flop, and answers with a one-cycle ok pulse.
module sram_word_ctrl #(
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [19:0] addr,
  input  logic [3:0]  be_n,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ok,
  inout  wire  [31:0] sram_data,
  output logic [19:0] sram_addr,
  output logic [3:0]  sram_be_n,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  localparam logic [3:0] RD_LAST = 4'(RD_WAIT);
  localparam logic [3:0] WR_LAST = 4'(WR_WAIT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] wdata_q;
  logic        bus_drv;

  assign sram_data = bus_drv ? wdata_q : 'z;

  // Pin values are assigned on the transition into a state, so each state's pins
  // are already on the flops during its first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wdata_q   <= 32'd0;
      bus_drv   <= 1'b0;
      rdata     <= 32'd0;
      ok        <= 1'b0;
      sram_addr <= 20'd0;
      sram_be_n <= 4'b0000;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
    end else begin
      ok <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            sram_addr <= addr;
            sram_be_n <= be_n;
            wdata_q   <= wdata;
            cnt       <= 4'd0;
            sram_ce_n <= 1'b0;
            sram_we_n <= 1'b1;
            if (wr) begin
              state     <= WR_SETUP;
              sram_oe_n <= 1'b1;
              bus_drv   <= 1'b1;
            end else begin
              state     <= RD;
              sram_oe_n <= 1'b0;
              bus_drv   <= 1'b0;
            end
          end
        end
        RD: begin
          if (cnt == RD_LAST) begin
            rdata     <= sram_data;
            ok        <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_SETUP: begin
          sram_we_n <= 1'b0;
          cnt       <= 4'd0;
          state     <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == WR_LAST) begin
            sram_we_n <= 1'b1;
            state     <= WR_HOLD;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_HOLD: begin
          // Address and data stay on the pins for this cycle after we_n has risen.
          ok        <= 1'b1;
          sram_ce_n <= 1'b1;
          bus_drv   <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          bus_drv   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: instance 0 uses the default waits, instance 1 uses RD_WAIT=0, WR_WAIT=1.
// Each instance talks to its own SRAM model; a monitor checks every ok pulse against a scoreboard.
module tb_sram_word_ctrl;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic        rst       [2];
  logic        req       [2];
  logic        wr        [2];
  logic [19:0] addr      [2];
  logic [3:0]  be_n      [2];
  logic [31:0] wdata     [2];
  logic [31:0] rdata     [2];
  logic        ok        [2];
  logic [19:0] sram_addr [2];
  logic [3:0]  sram_be_n [2];
  logic        ce_n      [2];
  logic        oe_n      [2];
  logic        we_n      [2];
  logic [31:0] bus_val   [2];

  // ok cycle after the request is first seen: RD_WAIT+2 and WR_WAIT+3 per instance.
  int RD_LAT [2] = '{3, 2};
  int WR_LAT [2] = '{5, 4};

  exp_t q0[$];
  exp_t q1[$];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    wire [31:0]  bus;
    logic [31:0] mem [1024];
    logic        init_done = 1'b0;

    // Board pull-ups: a released bus reads as all ones.
    pullup pu (bus);

    sram_word_ctrl #(
      .RD_WAIT(g == 0 ? 1 : 0),
      .WR_WAIT(g == 0 ? 2 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .req      (req[g]),
      .wr       (wr[g]),
      .addr     (addr[g]),
      .be_n     (be_n[g]),
      .wdata    (wdata[g]),
      .rdata    (rdata[g]),
      .ok       (ok[g]),
      .sram_data(bus),
      .sram_addr(sram_addr[g]),
      .sram_be_n(sram_be_n[g]),
      .sram_ce_n(ce_n[g]),
      .sram_oe_n(oe_n[g]),
      .sram_we_n(we_n[g])
    );

    assign bus = (!ce_n[g] && !oe_n[g] && we_n[g]) ? mem[sram_addr[g][9:0]] : 32'bz;
    assign bus_val[g] = bus;

    always @(posedge clk) begin
      if (!init_done) begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[10'h123] = 32'hDEADBEEF;
        mem[10'h007] = 32'h77777777;
        init_done = 1'b1;
      end else if (!ce_n[g] && !we_n[g]) begin
        for (int b = 0; b < 4; b++)
          if (!sram_be_n[g][b]) mem[sram_addr[g][9:0]][8*b +: 8] = bus[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, g, cyc, act, exp);
    end
  endtask

  task automatic pins(input string name, input int g, input logic [2:0] ce_oe_we);
    chk(name, g, {29'd0, ce_n[g], oe_n[g], we_n[g]}, {29'd0, ce_oe_we});
  endtask

  task automatic check_reset(input int g);
    pins("rst_pins", g, 3'b111);
    chk("rst_addr", g, {12'd0, sram_addr[g]}, 32'd0);
    chk("rst_be_n", g, {28'd0, sram_be_n[g]}, 32'd0);
    chk("rst_ok", g, {31'd0, ok[g]}, 32'd0);
    chk("rst_rdata", g, rdata[g], 32'd0);
    chk("rst_bus_released", g, bus_val[g], 32'hFFFFFFFF);
  endtask

  task automatic at_cycle(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_req(input int g, input logic w, input logic [19:0] a, input logic [3:0] be,
                           input logic [31:0] d, input logic [31:0] exp_rd, output int c0);
    exp_t e;
    req[g] = 1'b1;
    wr[g] = w;
    addr[g] = a;
    be_n[g] = be;
    wdata[g] = d;
    c0 = cyc;
    e.is_rd = !w;
    e.data = exp_rd;
    e.cyc = cyc + (w ? WR_LAT[g] : RD_LAT[g]);
    if (g == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic finish_req(input int g);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (ok[g] === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL ok_timeout inst%0d: no ok within 40 cycles", g);
    end
    @(posedge clk);
    #1;
    req[g] = 1'b0;
  endtask

  task automatic do_acc(input int g, input logic w, input logic [19:0] a, input logic [3:0] be,
                        input logic [31:0] d, input logic [31:0] exp_rd);
    int c0;
    start_req(g, w, a, be, d, exp_rd, c0);
    finish_req(g);
    idle(1);
  endtask

  task automatic rst_mid_write(input int g);
    int c0;
    start_req(g, 1'b1, 20'h0000A, 4'h0, 32'h12345678, 32'd0, c0);
    at_cycle(c0 + 1);
    @(posedge clk);
    #1;
    rst[g] = 1'b1;
    @(negedge clk);
    pins("pulse_before_rst", g, 3'b010);
    @(posedge clk);
    if (g == 0) q0.delete();
    else q1.delete();
    #1;
    rst[g] = 1'b0;
    // The request is still held, so it restarts from scratch in this cycle.
    start_req(g, 1'b1, 20'h0000A, 4'h0, 32'h12345678, 32'd0, c0);
    @(negedge clk);
    check_reset(g);
    finish_req(g);
    idle(1);
    do_acc(g, 1'b0, 20'h0000A, 4'h0, 32'd0, 32'h12345678);
  endtask

  logic prev_ok [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      if (ok[g] === 1'b1) begin
        chk("ok_single_cycle", g, {31'd0, prev_ok[g]}, 32'd0);
        if ((g == 0 ? q0.size() : q1.size()) == 0) begin
          tests++;
          fails++;
          $display("FAIL ok_unexpected inst%0d cycle %0d: ok with no access outstanding", g, cyc);
        end else begin
          e = (g == 0) ? q0.pop_front() : q1.pop_front();
          chk("ok_cycle", g, cyc, e.cyc);
          if (e.is_rd) chk("rdata", g, rdata[g], e.data);
          pins("done_pins", g, 3'b111);
          chk("done_bus_released", g, bus_val[g], 32'hFFFFFFFF);
        end
      end
      prev_ok[g] = ok[g];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1;
      req[g] = 1'b1;
      wr[g] = 1'b1;
      addr[g] = 20'h12345;
      be_n[g] = 4'h0;
      wdata[g] = 32'h0;
    end
    repeat (2) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) check_reset(g);
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b0;
      req[g] = 1'b0;
    end
    idle(1);

    // Single read: ce_n/oe_n low in cycles 1-2, ok with data in cycle 3.
    start_req(0, 1'b0, 20'h00123, 4'h0, 32'd0, 32'hDEADBEEF, c0);
    for (int n = 1; n <= 2; n++) begin
      at_cycle(c0 + n);
      pins("rd_pins", 0, 3'b001);
      chk("rd_addr", 0, {12'd0, sram_addr[0]}, 32'h00123);
    end
    finish_req(0);
    idle(1);

    // Single write: we_n low in cycles 2-3, bus driven in cycles 1-4, ok in cycle 5.
    start_req(0, 1'b1, 20'h00040, 4'h0, 32'hA5A51234, 32'd0, c0);
    for (int n = 1; n <= 4; n++) begin
      at_cycle(c0 + n);
      pins("wr_pins", 0, (n == 2 || n == 3) ? 3'b010 : 3'b011);
      chk("wr_bus", 0, bus_val[0], 32'hA5A51234);
      chk("wr_addr", 0, {12'd0, sram_addr[0]}, 32'h00040);
    end
    finish_req(0);
    idle(1);
    do_acc(0, 1'b0, 20'h00040, 4'h0, 32'd0, 32'hA5A51234);

    // Lanes 1 and 3 enabled: 0xA5A51234 becomes 0x00A50034.
    do_acc(0, 1'b1, 20'h00040, 4'b0101, 32'h00FF00FF, 32'd0);
    do_acc(0, 1'b0, 20'h00040, 4'h0, 32'd0, 32'h00A50034);

    // Back-to-back: write ok in cycle 5, read sampled in cycle 6, read ok in cycle 9.
    start_req(0, 1'b1, 20'h00005, 4'h0, 32'h11111111, 32'd0, c0);
    finish_req(0);
    start_req(0, 1'b0, 20'h00005, 4'h0, 32'd0, 32'h11111111, c0);
    finish_req(0);
    idle(1);

    // Inputs change during WR_PULSE; the latched address and data must win.
    start_req(0, 1'b1, 20'h00009, 4'h0, 32'hCAFEF00D, 32'd0, c0);
    at_cycle(c0 + 1);
    @(posedge clk);
    #1;
    addr[0] = 20'h00007;
    wdata[0] = 32'd0;
    at_cycle(c0 + 3);
    chk("chg_addr_pin", 0, {12'd0, sram_addr[0]}, 32'h00009);
    chk("chg_bus", 0, bus_val[0], 32'hCAFEF00D);
    finish_req(0);
    idle(1);
    do_acc(0, 1'b0, 20'h00009, 4'h0, 32'd0, 32'hCAFEF00D);
    do_acc(0, 1'b0, 20'h00007, 4'h0, 32'd0, 32'h77777777);

    rst_mid_write(0);

    // Minimum waits: read ok in cycle 2, write ok in cycle 4.
    do_acc(1, 1'b0, 20'h00123, 4'h0, 32'd0, 32'hDEADBEEF);
    do_acc(1, 1'b1, 20'h00040, 4'h0, 32'h5A5A0F0F, 32'd0);
    do_acc(1, 1'b0, 20'h00040, 4'h0, 32'd0, 32'h5A5A0F0F);
    rst_mid_write(1);

    idle(4);
    chk("sb_drained", 0, q0.size(), 32'd0);
    chk("sb_drained", 1, q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
